// File: rtl/pin_controller.sv
// Memory-mapped GPIO target: per-pin output/enable registers, synchronised inputs,
// rising/falling edge capture into PENDING with a level interrupt.
module pin_controller #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_request,
  input  logic              i_rw,
  input  logic [2:0]        i_address,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_ready,
  output logic              o_interrupt,
  output logic [WIDTH-1:0]  o_pin_out,
  output logic [WIDTH-1:0]  o_pin_oe,
  input  logic [WIDTH-1:0]  i_pin_in
);

  typedef enum logic [0:0] {StIdle, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;

  logic             accept;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rd_val;
  logic             unused_wdata;

  // Bits of the write bus above WIDTH are intentionally ignored.
  assign unused_wdata = ^i_wdata;

  assign accept = (state_q == StIdle) && i_request;
  assign wdata  = i_wdata[WIDTH-1:0];
  assign rise   = s2_q & ~s3_q;
  assign fall   = ~s2_q & s3_q;

  // Handshake FSM: state register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_request) state_d = StDone;
      StDone: if (!i_request) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake FSM: outputs
  always_comb begin
    o_ready = (state_q == StDone);
  end

  always_comb begin
    rd_val = '0;
    unique case (i_address)
      3'd0:    rd_val = out_q;
      3'd1:    rd_val = oe_q;
      3'd2:    rd_val = s2_q;
      3'd5:    rd_val = rise_en_q;
      3'd6:    rd_val = fall_en_q;
      3'd7:    rd_val = pend_q;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (accept && i_rw) begin
      unique case (i_address)
        3'd0:    out_d     = wdata;
        3'd1:    oe_d      = wdata;
        3'd3:    out_d     = out_q | wdata;
        3'd4:    out_d     = out_q & ~wdata;
        3'd5:    rise_en_d = wdata;
        3'd6:    fall_en_d = wdata;
        3'd7:    w1c       = wdata;
        default: ;
      endcase
    end
    // A fresh edge beats a simultaneous clear of the same bit.
    pend_d = (pend_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = i_rw ? 32'd0 : 32'(rd_val);
    end else if ((state_q == StDone) && !i_request) begin
      rdata_d = 32'd0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      out_q     <= RESET_OUT;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      s1_q      <= i_pin_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      rdata_q   <= rdata_d;
      irq_q     <= |pend_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_interrupt = irq_q;
  assign o_pin_out   = out_q;
  assign o_pin_oe    = oe_q;

endmodule

// File: tb/tb_pin_controller.sv
// Bench for pin_controller (WIDTH=8, RESET_OUT=8'hA5): directed table, corner sequences,
// and random traffic checked every cycle against a cycle-history reference model.
module tb_pin_controller;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [2:0]  i_address = 3'd0;
  logic [31:0] i_wdata = 32'd0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_interrupt;
  logic [7:0]  o_pin_out;
  logic [7:0]  o_pin_oe;
  logic [7:0]  i_pin_in = 8'h00;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  pin_controller #(
    .WIDTH     (8),
    .RESET_OUT (8'hA5)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_request   (i_request),
    .i_rw        (i_rw),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_ready     (o_ready),
    .o_interrupt (o_interrupt),
    .o_pin_out   (o_pin_out),
    .o_pin_oe    (o_pin_oe),
    .i_pin_in    (i_pin_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. ph[k] is the pin value seen at the edge k cycles ago (ph[0] = this edge).
  logic [7:0]  m_out = 8'hA5, m_oe = 8'h00, m_rise = 8'h00, m_fall = 8'h00, m_pend = 8'h00;
  logic        m_done = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [7:0]  ph [$] = '{8'h00, 8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin : model
    logic [7:0] rise, fall, w1c, rd, wd;
    logic       acc;
    if (!i_reset) begin
      m_out = 8'hA5; m_oe = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_pend = 8'h00;
      m_done = 1'b0; m_rdata = 32'd0;
      ph = '{8'h00, 8'h00, 8'h00, 8'h00};
    end else begin
      ph.push_front(i_pin_in);
      void'(ph.pop_back());
      rise = ph[2] & ~ph[3];
      fall = ~ph[2] & ph[3];
      acc  = !m_done && i_request;
      wd   = i_wdata[7:0];
      w1c  = (acc && i_rw && i_address == 3'd7) ? wd : 8'h00;
      case (i_address)
        3'd0: rd = m_out;
        3'd1: rd = m_oe;
        3'd2: rd = ph[2];
        3'd5: rd = m_rise;
        3'd6: rd = m_fall;
        3'd7: rd = m_pend;
        default: rd = 8'h00;
      endcase
      m_pend = (m_pend & ~w1c) | (rise & m_rise) | (fall & m_fall);
      if (acc) begin
        if (i_rw) begin
          case (i_address)
            3'd0: m_out = wd;
            3'd1: m_oe = wd;
            3'd3: m_out = m_out | wd;
            3'd4: m_out = m_out & ~wd;
            3'd5: m_rise = wd;
            3'd6: m_fall = wd;
            default: ;
          endcase
        end
        m_rdata = i_rw ? 32'd0 : {24'd0, rd};
        m_done  = 1'b1;
      end else if (m_done && !i_request) begin
        m_done  = 1'b0;
        m_rdata = 32'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pin_out", {24'd0, o_pin_out}, {24'd0, m_out});
      check("pin_oe", {24'd0, o_pin_oe}, {24'd0, m_oe});
      check("ready", {31'd0, o_ready}, {31'd0, m_done});
      check("interrupt", {31'd0, o_interrupt}, {31'd0, (m_pend != 8'h00)});
      check("rdata", o_rdata, m_rdata);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after an edge; returns just after an edge with the DUT idle again.
  task automatic bus(input logic rw, input logic [2:0] addr, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd);
    int n;
    i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wd;
    step(1);
    check("ready_latency", {31'd0, o_ready}, 32'd1);
    n = 0;
    while (!o_ready && n < 4) begin
      step(1);
      n++;
    end
    if (!o_ready) begin
      check("ready_timeout", {31'd0, o_ready}, 32'd1);
      i_request = 1'b0;
      step(2);
      rd = 32'd0;
      return;
    end
    rd = o_rdata;
    for (int i = 1; i < hold; i++) begin
      step(1);
      check("ready_held", {31'd0, o_ready}, 32'd1);
      check("rdata_stable", o_rdata, rd);
    end
    i_request = 1'b0;
    step(1);
    check("ready_drop", {31'd0, o_ready}, 32'd0);
    check("rdata_clear", o_rdata, 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs [$];

  initial begin : main
    logic [31:0] rd;

    vecs.push_back('{1'b0, 3'd7, 32'h0,         32'h0,  8'hA5, 8'h00});
    vecs.push_back('{1'b0, 3'd0, 32'h0,         32'hA5, 8'hA5, 8'h00});
    vecs.push_back('{1'b1, 3'd0, 32'h0000_01C3, 32'h0,  8'hC3, 8'h00});
    vecs.push_back('{1'b0, 3'd0, 32'h0,         32'hC3, 8'hC3, 8'h00});
    vecs.push_back('{1'b1, 3'd0, 32'h0F,        32'h0,  8'h0F, 8'h00});
    vecs.push_back('{1'b1, 3'd3, 32'h30,        32'h0,  8'h3F, 8'h00});
    vecs.push_back('{1'b1, 3'd4, 32'h05,        32'h0,  8'h3A, 8'h00});
    vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0,  8'h3A, 8'h00});
    vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0,  8'h3A, 8'h00});
    vecs.push_back('{1'b1, 3'd1, 32'hFF5A,      32'h0,  8'h3A, 8'h5A});
    vecs.push_back('{1'b0, 3'd1, 32'h0,         32'h5A, 8'h3A, 8'h5A});
    vecs.push_back('{1'b1, 3'd2, 32'hFF,        32'h0,  8'h3A, 8'h5A});
    vecs.push_back('{1'b0, 3'd2, 32'h0,         32'h0,  8'h3A, 8'h5A});
    vecs.push_back('{1'b1, 3'd3, 32'h100,       32'h0,  8'h3A, 8'h5A});
    vecs.push_back('{1'b1, 3'd4, 32'hFFFF_FF00, 32'h0,  8'h3A, 8'h5A});

    // Reset held for two edges.
    step(2);
    chk_en = 1'b1;
    check("rst_pin_out", {24'd0, o_pin_out}, 32'hA5);
    check("rst_pin_oe", {24'd0, o_pin_oe}, 32'h0);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_irq", {31'd0, o_interrupt}, 32'd0);
    i_reset = 1'b1;
    step(1);

    foreach (vecs[i]) begin
      bus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, (i == 2) ? 5 : 1, rd);
      if (!vecs[i].rw) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_out", i), {24'd0, o_pin_out}, {24'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_oe", i), {24'd0, o_pin_oe}, {24'd0, vecs[i].exp_oe});
    end

    // Input synchroniser: a read issued 3 cycles after the change sees it.
    i_pin_in = 8'h81;
    step(2);
    bus(1'b0, 3'd2, 32'h0, 1, rd);
    check("in_sync", rd, 32'h81);
    bus(1'b0, 3'd7, 32'h0, 1, rd);
    check("no_pend_disabled", rd, 32'h0);

    // Edge capture.
    bus(1'b1, 3'd5, 32'h01, 1, rd);
    bus(1'b1, 3'd6, 32'h80, 1, rd);
    i_pin_in = 8'h80;
    step(4);
    i_pin_in = 8'h81;
    step(2);
    check("irq_before_3rd_edge", {31'd0, o_interrupt}, 32'd0);
    step(1);
    check("irq_at_3rd_edge", {31'd0, o_interrupt}, 32'd1);
    bus(1'b0, 3'd7, 32'h0, 1, rd);
    check("pend_rise", rd, 32'h01);
    i_pin_in = 8'h01;
    step(4);
    bus(1'b0, 3'd7, 32'h0, 1, rd);
    check("pend_fall", rd, 32'h81);
    bus(1'b1, 3'd7, 32'h01, 1, rd);
    bus(1'b0, 3'd7, 32'h0, 1, rd);
    check("pend_w1c_one", rd, 32'h80);
    check("irq_still_set", {31'd0, o_interrupt}, 32'd1);
    bus(1'b1, 3'd7, 32'h80, 1, rd);
    check("irq_cleared", {31'd0, o_interrupt}, 32'd0);

    // Collision: rising edge lands on the same edge as the W1C of that bit.
    i_pin_in = 8'h00;
    step(4);
    i_pin_in = 8'h01;
    step(4);
    i_pin_in = 8'h00;
    step(4);
    i_pin_in = 8'h01;
    step(2);
    bus(1'b1, 3'd7, 32'h01, 1, rd);
    bus(1'b0, 3'd7, 32'h0, 1, rd);
    check("collision_keeps_bit", rd, 32'h01);
    bus(1'b1, 3'd7, 32'h01, 1, rd);
    bus(1'b0, 3'd7, 32'h0, 1, rd);
    check("w1c_no_collision", rd, 32'h00);

    // Reset during DONE aborts; reset on the accepting edge suppresses the write.
    i_request = 1'b1; i_rw = 1'b1; i_address = 3'd1; i_wdata = 32'h33;
    step(1);
    check("abort_pre_ready", {31'd0, o_ready}, 32'd1);
    i_reset = 1'b0;
    step(1);
    check("abort_ready", {31'd0, o_ready}, 32'd0);
    check("abort_out", {24'd0, o_pin_out}, 32'hA5);
    check("abort_oe", {24'd0, o_pin_oe}, 32'h0);
    check("abort_irq", {31'd0, o_interrupt}, 32'd0);
    i_address = 3'd0; i_wdata = 32'h11;
    step(1);
    check("reset_blocks_write", {24'd0, o_pin_out}, 32'hA5);
    i_request = 1'b0;
    step(1);
    i_reset = 1'b1;
    step(1);
    bus(1'b0, 3'd5, 32'h0, 1, rd);
    check("abort_rise_en", rd, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) i_pin_in = 8'($urandom);
      bus(1'($urandom), 3'($urandom), $urandom, $urandom_range(1, 3), rd);
      if ($urandom_range(0, 2) == 0) begin
        i_pin_in = 8'($urandom);
        step($urandom_range(1, 4));
      end
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pin_controller.md
Name: pin_controller

Overview:
- Memory-mapped GPIO peripheral that decodes the 0x4xxxxxxx bus region (pin_select) and drives the SoC bus ready signal for that region.
- Sits downstream of the CPU bus multiplexer, alongside the ROM, RAM and UART targets.
- Provides per-pin output data and output enables, synchronised input sampling, and rising/falling edge capture with a level interrupt.
- Uses the same request/ready handshake as the other bus targets.

Parameters:
- WIDTH, 8: number of pins, 1..32. Register bits at WIDTH and above read 0; writes to them are ignored.
- RESET_OUT, 0: reset value of the OUT register (WIDTH bits).

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_request  in  1  bus request, held by the master until o_ready.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  3  register word index.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, valid while o_ready = 1.
- o_ready  out  1  access complete.
- o_interrupt  out  1  level interrupt, high when any pending bit is set.
- o_pin_out  out  WIDTH  pin output values.
- o_pin_oe  out  WIDTH  pin output enables (1 = drive).
- i_pin_in  in  WIDTH  asynchronous pin inputs.

Behaviour:
- Reset (i_reset = 0 at a clock edge) sets:
  - OUT = RESET_OUT; OE, RISE_EN, FALL_EN, PENDING = 0.
  - Synchroniser and edge-history flops = 0.
  - o_ready = 0, o_rdata = 0, o_interrupt = 0.
  - Reset asserted during an access aborts it; no write side effect after that edge.
- Register map (i_address):
  - 0 OUT: read/write.
  - 1 OE: read/write.
  - 2 IN: read-only; returns synchronised inputs; writes ignored.
  - 3 SET: write-only, OUT |= wdata; reads 0.
  - 4 CLR: write-only, OUT &= ~wdata; reads 0.
  - 5 RISE_EN: read/write.
  - 6 FALL_EN: read/write.
  - 7 PENDING: read; write-1-to-clear.
- Handshake state machine, states IDLE and DONE:
  - IDLE: if i_request = 1, perform the access in that cycle (register update, or capture read data into o_rdata). Next cycle: state DONE, o_ready = 1.
  - DONE: o_ready stays 1 and o_rdata stays stable while i_request = 1. When i_request = 0: o_ready = 0 next cycle, o_rdata = 0, return to IDLE.
  - Latency: o_ready rises exactly 1 cycle after i_request is first seen high in IDLE.
  - Exactly one side effect per request, even if i_request is held for many cycles.
  - A request that is dropped and re-raised is a new access. It is first sampled in IDLE, so back-to-back accesses take at least 2 cycles each.
- o_pin_out = OUT and o_pin_oe = OE, both driven directly from registers; a change is visible the cycle after the write is accepted.
- Input path:
  - 2-flop synchroniser s1 -> s2; history flop s3 <= s2.
  - IN reads s2.
  - Rising edge = s2 & ~s3; falling edge = ~s2 & s3.
  - A change on i_pin_in is visible in IN 2 cycles later.
  - An edge sets PENDING on the 3rd edge after the input change (2 synchroniser stages, then the compare that sets PENDING).
  - The history flops must not create an edge on the first cycle after reset.
- PENDING update, each cycle: PENDING <= (PENDING & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - w1c = i_wdata only during an accepted write to address 7; otherwise 0.
  - A new edge in the same cycle as a W1C of that bit wins: the bit stays set.
- o_interrupt is registered: o_interrupt <= |PENDING (uses next-state PENDING), so it follows PENDING with no extra cycle.
- Width rules:
  - All registers are WIDTH bits; reads zero-extend to 32.
  - SET/CLR with bits >= WIDTH have no effect.
  - WIDTH = 32 has no unused bits.

Test Plan:
- Reset: hold i_reset = 0 for 2 cycles with RESET_OUT = 8'hA5 -> o_pin_out = 8'hA5; o_pin_oe, o_ready, o_interrupt = 0; a read of address 7 returns 0.
- Write then read: write OUT = 32'h0000_01C3 (WIDTH = 8) -> o_ready 1 cycle after request, o_pin_out = 8'hC3. Read address 0 -> o_rdata = 32'h0000_00C3. Request held 5 cycles -> single write, o_ready high until the request drops.
- SET/CLR: OUT = 8'h0F; SET 8'h30 -> 8'h3F; CLR 8'h05 -> 8'h3A. Reads of addresses 3 and 4 return 0.
- Input sync: i_pin_in goes 8'h00 -> 8'h81 at cycle t -> a read of IN issued at t+3 or later returns 32'h81. No PENDING bits set while RISE_EN = FALL_EN = 0.
- Edge capture: RISE_EN = 8'h01, FALL_EN = 8'h80. Pin0 rises -> PENDING = 8'h01 and o_interrupt = 1 by t+3. Pin7 falls -> PENDING = 8'h81. W1C 8'h01 -> PENDING = 8'h80, o_interrupt stays 1. W1C 8'h80 -> o_interrupt = 0.
- Collision and abort:
  - Pin0 rising edge lands in the same cycle as a W1C 8'h01 -> PENDING[0] stays 1.
  - i_reset = 0 asserted during DONE -> next cycle o_ready = 0 and all registers at their reset values.
